core_mem_arbiter: RTL and testbench

//  Sits directly downstream of the core's two memory ports and merges iram_* (fetch) and dram_* (load/store)

---
 rtl/core_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_core_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - merges fetch and load/store ports onto one memory port with in-order response steering
module core_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int OSTD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,

    input  logic              iram_req,
    input  logic              iram_write,
    input  logic [XLEN/8-1:0] iram_wstrb,
    input  logic [XLEN-1:0]   iram_addr,
    input  logic [XLEN-1:0]   iram_wdata,
    output logic              iram_ready,
    output logic              iram_rvalid,
    output logic [XLEN-1:0]   iram_rdata,

    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_ready,
    output logic              dram_rvalid,
    output logic [XLEN-1:0]   dram_rdata,

    output logic              mem_req,
    output logic              mem_write,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic              rsp_err
);

    localparam int PW = $clog2(OSTD_DEPTH);
    localparam int CW = $clog2(OSTD_DEPTH + 1);

    logic [OSTD_DEPTH-1:0] tag_mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  rr_ptr;
    logic                  err_q;

    logic full;
    logic empty;
    logic dram_elig;
    logic iram_elig;
    logic tie;
    logic gnt_iram;
    logic req_any;
    logic accept;
    logic push;
    logic pop;
    logic head_iram;

    assign full  = (count == CW'(OSTD_DEPTH));
    assign empty = (count == '0);

    // A read is only eligible while a tag slot is free; writes are never blocked.
    assign dram_elig = dram_req & (dram_write | ~full);
    assign iram_elig = iram_req & (iram_write | ~full);
    assign tie       = dram_elig & iram_elig;
    assign gnt_iram  = tie ? rr_ptr : iram_elig;
    assign req_any   = (dram_elig | iram_elig) & rst_b;
    assign accept    = req_any & mem_ready;
    assign push      = accept & ~mem_write;
    assign pop       = mem_rvalid & ~empty;
    assign head_iram = tag_mem[rd_ptr];

    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (req_any) begin
            mem_req = 1'b1;
            if (gnt_iram) begin
                mem_write = iram_write;
                mem_wstrb = iram_wstrb;
                mem_addr  = iram_addr;
                mem_wdata = iram_wdata;
            end else begin
                mem_write = dram_write;
                mem_wstrb = dram_wstrb;
                mem_addr  = dram_addr;
                mem_wdata = dram_wdata;
            end
        end
    end

    assign iram_ready  = accept & gnt_iram;
    assign dram_ready  = accept & ~gnt_iram;
    assign iram_rvalid = pop & rst_b & head_iram;
    assign dram_rvalid = pop & rst_b & ~head_iram;
    assign iram_rdata  = rst_b ? mem_rdata : '0;
    assign dram_rdata  = rst_b ? mem_rdata : '0;
    assign rsp_err     = err_q & rst_b;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_ptr  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= gnt_iram;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (tie && accept) begin
                rr_ptr <= ~rr_ptr;
            end
            if (mem_rvalid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - randomized bench for core_mem_arbiter against a queue-based reference model
module tb_core_mem_arbiter;

    localparam int XLEN = 32;
    localparam int D    = 4;
    localparam int SW   = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            iram_req = 0, iram_write = 0;
    logic [SW-1:0]   iram_wstrb = '0;
    logic [XLEN-1:0] iram_addr = '0, iram_wdata = '0;
    logic            iram_ready, iram_rvalid;
    logic [XLEN-1:0] iram_rdata;
    logic            dram_req = 0, dram_write = 0;
    logic [SW-1:0]   dram_wstrb = '0;
    logic [XLEN-1:0] dram_addr = '0, dram_wdata = '0;
    logic            dram_ready, dram_rvalid;
    logic [XLEN-1:0] dram_rdata;
    logic            mem_req, mem_write;
    logic [SW-1:0]   mem_wstrb;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_ready = 0, mem_rvalid = 0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            rsp_err;

    always #5 clk = ~clk;

    core_mem_arbiter #(.XLEN(XLEN), .OSTD_DEPTH(D)) dut (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_ready(iram_ready),
        .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_err(rsp_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue of outstanding read owners (1=iram), favoured port, sticky error.
    bit tagq[$];
    bit rr_iram;
    bit err;
    bit d_pend, i_pend;
    int full_seen;

    task automatic model_reset();
        tagq.delete();
        rr_iram = 0;
        err     = 0;
    endtask

    task automatic new_requests(input int p_req);
        if (!d_pend && $urandom_range(99) < p_req) begin
            d_pend     = 1;
            dram_write = 1'($urandom_range(1));
            dram_wstrb = SW'($urandom);
            dram_addr  = $urandom;
            dram_wdata = $urandom;
        end
        if (!i_pend && $urandom_range(99) < p_req) begin
            i_pend     = 1;
            iram_write = 1'($urandom_range(3) == 0);
            iram_wstrb = SW'($urandom);
            iram_addr  = $urandom;
            iram_wdata = $urandom;
        end
        dram_req = d_pend;
        iram_req = i_pend;
    endtask

    task automatic check_cycle();
        bit full, ed, ei, gi, ereq, acc, gw, rv, head;
        full = (tagq.size() == D);
        if (full) full_seen++;
        ed   = dram_req && (dram_write || !full);
        ei   = iram_req && (iram_write || !full);
        gi   = (ed && ei) ? rr_iram : ei;
        ereq = ed || ei;
        acc  = ereq && mem_ready;
        gw   = gi ? iram_write : dram_write;
        check_eq("mem_req", mem_req, ereq);
        if (ereq) begin
            check_eq("mem_write", mem_write, gw);
            check_eq("mem_addr", mem_addr, gi ? iram_addr : dram_addr);
            check_eq("mem_wdata", mem_wdata, gi ? iram_wdata : dram_wdata);
            check_eq("mem_wstrb", mem_wstrb, gi ? iram_wstrb : dram_wstrb);
        end
        check_eq("dram_ready", dram_ready, acc && !gi);
        check_eq("iram_ready", iram_ready, acc && gi);
        rv   = mem_rvalid && (tagq.size() > 0);
        head = (tagq.size() > 0) ? tagq[0] : 1'b0;
        check_eq("dram_rvalid", dram_rvalid, rv && !head);
        check_eq("iram_rvalid", iram_rvalid, rv && head);
        check_eq("dram_rdata", dram_rdata, mem_rdata);
        check_eq("iram_rdata", iram_rdata, mem_rdata);
        check_eq("rsp_err", rsp_err, err);

        if (mem_rvalid && tagq.size() == 0) err = 1;
        if (rv) void'(tagq.pop_front());
        if (acc && !gw) tagq.push_back(gi);
        if (ed && ei && acc) rr_iram = !rr_iram;
        if (acc) begin
            if (gi) i_pend = 0;
            else    d_pend = 0;
        end
    endtask

    task automatic run_phase(input int n, input int p_req, input int p_rdy, input int p_rv, input bit unexp);
        for (int c = 0; c < n; c++) begin
            new_requests(p_req);
            mem_ready  = ($urandom_range(99) < p_rdy);
            mem_rvalid = (tagq.size() > 0 || unexp) && ($urandom_range(99) < p_rv);
            mem_rdata  = $urandom;
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        model_reset();
        d_pend = 0;
        i_pend = 0;
        full_seen = 0;
        dram_req = 1;
        iram_req = 1;
        mem_rvalid = 1;
        mem_ready = 1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_ready", {iram_ready, dram_ready}, 0);
        check_eq("rst_rvalid", {iram_rvalid, dram_rvalid}, 0);
        check_eq("rst_rdata", dram_rdata, 0);
        check_eq("rst_err", rsp_err, 0);
        dram_req = 0;
        iram_req = 0;
        mem_rvalid = 0;
        @(posedge clk);
        #1;
        rst_b = 1;

        run_phase(400, 60, 80, 50, 0);
        run_phase(400, 90, 90, 8, 0);
        run_phase(300, 70, 60, 40, 0);

        // Reset mid-operation with reads outstanding; later responses must be flagged.
        run_phase(200, 90, 90, 5, 0);
        rst_b = 0;
        @(negedge clk);
        check_eq("midrst_mem_req", mem_req, 0);
        check_eq("midrst_ready", {iram_ready, dram_ready}, 0);
        check_eq("midrst_rvalid", {iram_rvalid, dram_rvalid}, 0);
        check_eq("midrst_err", rsp_err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_b = 1;
        dram_req = 0;
        iram_req = 0;
        mem_ready = 0;
        mem_rvalid = 1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        run_phase(300, 60, 70, 50, 1);
        run_phase(300, 80, 80, 30, 0);

        check_eq("full_reached", full_seen > 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
